bubble_sort_controller: RTL

Sequencing FSM that drives the four-entry register datapath of the bubble sort machine. Each cycle it selects two adjacent entries through the four-input read muxes and compares them. When they are out of order it swaps them through a temp register, using the write decoder and the two-input write-source mux. It sits directly upstream of the register/mux/decoder datapath and owns no array storage.

---
 rtl/sort_pkg.sv | 17 +
 rtl/sort_compare.sv | 17 +
 rtl/bubble_sort_controller.sv | 127 ++++++++++++
 3 files changed

// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared states and sizing for the bubble sort controller
package sort_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITE_LO,
    WRITE_HI,
    DONE
  } sort_state_t;

  localparam int N_ENTRIES  = 4;
  localparam int IDX_W      = 2;
  localparam int LAST_PASS  = 2;
  localparam int SWAP_CNT_W = 8;

endpackage

// File: rtl/sort_compare.sv
// rtl/sort_compare.sv - swap decision for one adjacent pair (SORT_DESCENDING_EN selects order)
module sort_compare #(
  parameter int K = 32
) (
  input  logic [K-1:0] a_data,
  input  logic [K-1:0] b_data,
  output logic         swap
);

  // Strict comparison so equal entries keep their order in both modes
`ifdef SORT_DESCENDING_EN
  assign swap = (a_data < b_data);
`else
  assign swap = (a_data > b_data);
`endif

endmodule

// File: rtl/bubble_sort_controller.sv
// rtl/bubble_sort_controller.sv - sequencing FSM for the four-entry bubble sort datapath
// Sort order set by SORT_DESCENDING_EN inside sort_compare.
module bubble_sort_controller
  import sort_pkg::*;
#(
  parameter int K = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [K-1:0]          a_data,
  input  logic [K-1:0]          b_data,
  output logic [1:0]            rd_a_sel,
  output logic [1:0]            rd_b_sel,
  output logic                  tmp_en,
  output logic                  wr_en,
  output logic [1:0]            wr_idx,
  output logic                  wr_src,
  output logic                  busy,
  output logic                  done,
  output logic [SWAP_CNT_W-1:0] swap_count
);

  sort_state_t      state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] pass;
  logic             swap;

  sort_state_t      adv_state;
  logic [IDX_W-1:0] adv_idx;
  logic [IDX_W-1:0] adv_pass;
  logic [IDX_W-1:0] last_idx;

  sort_compare #(.K(K)) u_cmp (
    .a_data (a_data),
    .b_data (b_data),
    .swap   (swap)
  );

  assign rd_a_sel = idx;
  assign rd_b_sel = idx + IDX_W'(1);
  assign tmp_en   = (state == COMPARE) && swap;

  // Each pass shortens by one: pass p ends at idx = LAST_PASS - p
  assign last_idx = IDX_W'(LAST_PASS) - pass;

  always_comb begin
    adv_state = COMPARE;
    adv_idx   = idx;
    adv_pass  = pass;
    if (idx < last_idx) begin
      adv_idx = idx + IDX_W'(1);
    end else if (pass < IDX_W'(LAST_PASS)) begin
      adv_pass = pass + IDX_W'(1);
      adv_idx  = '0;
    end else begin
      adv_state = DONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      pass       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wr_en      <= 1'b0;
      wr_idx     <= '0;
      wr_src     <= 1'b0;
      swap_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= COMPARE;
            idx        <= '0;
            pass       <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            swap_count <= '0;
          end
        end
        COMPARE: begin
          if (swap) begin
            state  <= WRITE_LO;
            wr_en  <= 1'b1;
            wr_idx <= idx;
            wr_src <= 1'b0;
          end else begin
            state <= adv_state;
            idx   <= adv_idx;
            pass  <= adv_pass;
            busy  <= (adv_state != DONE);
            done  <= (adv_state == DONE);
          end
        end
        WRITE_LO: begin
          state  <= WRITE_HI;
          wr_en  <= 1'b1;
          wr_idx <= idx + IDX_W'(1);
          wr_src <= 1'b1;
        end
        WRITE_HI: begin
          if (swap_count != '1) begin
            swap_count <= swap_count + SWAP_CNT_W'(1);
          end
          state  <= adv_state;
          idx    <= adv_idx;
          pass   <= adv_pass;
          busy   <= (adv_state != DONE);
          done   <= (adv_state == DONE);
          wr_en  <= 1'b0;
          wr_idx <= '0;
          wr_src <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          wr_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
